// File: rtl/dcache_port_arbiter.sv
// Registered-grant arbiter sharing the single dcache port between the two EXM lanes.
// Tracks the owner of every outstanding read and steers in-order read data back to that lane.
module dcache_port_arbiter #(
    parameter int MAX_OUTST = 4,
    parameter int REQ_WD    = 106
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [REQ_WD-1:0] req0_bus,
    output logic              req0_ready,
    output logic              rsp0_rvalid,
    output logic [31:0]       rsp0_rdata,
    input  logic [REQ_WD-1:0] req1_bus,
    output logic              req1_ready,
    output logic              rsp1_rvalid,
    output logic [31:0]       rsp1_rdata,
    output logic [REQ_WD-1:0] dc_req_bus,
    input  logic              dc_ready,
    input  logic              dc_rvalid,
    input  logic [31:0]       dc_rdata
);

    localparam int VALID_BIT    = REQ_WD - 1;
    localparam int OP_BIT       = REQ_WD - 2;
    localparam int CACOP_EN_BIT = 34;
    localparam int PTR_W        = $clog2(MAX_OUTST);
    localparam int CNT_W        = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } state_t;

    function automatic logic is_read(input logic [REQ_WD-1:0] bus);
        return bus[VALID_BIT] & ~bus[OP_BIT] & ~bus[CACOP_EN_BIT];
    endfunction

    state_t               state_q, state_d;
    logic                 gnt_valid, gnt_lane;
    logic [REQ_WD-1:0]    gnt_bus;
    logic                 accept, push, pop;
    logic                 fifo_full, fifo_empty;
    logic                 head_owner, head_drop;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [MAX_OUTST-1:0] owner_mem, discard_mem;
    logic [31:0]          rdata0_q, rdata1_q;

    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A lane0 read blocked by a full FIFO also blocks lane1, keeping program order.
    always_comb begin
        // NOTE: defaults on every comb output first, so no path can infer a latch.
        gnt_valid = 1'b0;
        gnt_lane  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0_bus[VALID_BIT]) begin
                    gnt_valid = ~(is_read(req0_bus) & fifo_full);
                end else if (req1_bus[VALID_BIT]) begin
                    gnt_valid = ~(is_read(req1_bus) & fifo_full);
                    gnt_lane  = 1'b1;
                end
            end
            HOLD0: gnt_valid = 1'b1;
            HOLD1: begin
                gnt_valid = 1'b1;
                gnt_lane  = 1'b1;
            end
            default: ;
        endcase
        if (gnt_valid && !dc_ready) state_d = gnt_lane ? HOLD1 : HOLD0;
        else                        state_d = IDLE;
    end

    always_comb begin
        gnt_bus     = gnt_lane ? req1_bus : req0_bus;
        accept      = gnt_valid & dc_ready & ~reset;
        dc_req_bus  = (gnt_valid && !reset) ? gnt_bus : '0;
        req0_ready  = accept & ~gnt_lane;
        req1_ready  = accept & gnt_lane;
        push        = accept & is_read(gnt_bus);
        pop         = dc_rvalid & ~fifo_empty & ~reset;
        head_owner  = owner_mem[rd_ptr];
        head_drop   = discard_mem[rd_ptr] | flush;
        rsp0_rvalid = pop & ~head_drop & ~head_owner;
        rsp1_rvalid = pop & ~head_drop & head_owner;
        rsp0_rdata  = rsp0_rvalid ? dc_rdata : rdata0_q;
        rsp1_rdata  = rsp1_rvalid ? dc_rdata : rdata1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (rsp0_rvalid) rdata0_q <= dc_rdata;
            if (rsp1_rvalid) rdata1_q <= dc_rdata;
        end
    end

    // NOTE: owner storage has no reset; an entry is only read after a push has written it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUTST; i++) begin
            if (push && wr_ptr == PTR_W'(i)) begin
                owner_mem[i]   <= gnt_lane;
                discard_mem[i] <= flush;
            end else if (flush) begin
                discard_mem[i] <= 1'b1;
            end
        end
    end

    held_valid_kept: assert property (@(posedge clk) disable iff (reset)
        (state_q != IDLE) |-> gnt_bus[VALID_BIT]);

    rvalid_has_owner: assert property (@(posedge clk) disable iff (reset)
        dc_rvalid |-> !fifo_empty);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter: directed scenarios plus random traffic
// compared against a queue-based reference model of the arbitration and response routing.
module tb_dcache_port_arbiter;

    localparam int MAX_OUTST = 4;
    localparam int REQ_WD    = 106;

    logic              clk = 1'b0;
    logic              reset, flush;
    logic [REQ_WD-1:0] req0_bus, req1_bus, dc_req_bus;
    logic              req0_ready, req1_ready, rsp0_rvalid, rsp1_rvalid;
    logic [31:0]       rsp0_rdata, rsp1_rdata;
    logic              dc_ready, dc_rvalid;
    logic [31:0]       dc_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter #(.MAX_OUTST(MAX_OUTST), .REQ_WD(REQ_WD)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req0_bus   (req0_bus),
        .req0_ready (req0_ready),
        .rsp0_rvalid(rsp0_rvalid),
        .rsp0_rdata (rsp0_rdata),
        .req1_bus   (req1_bus),
        .req1_ready (req1_ready),
        .rsp1_rvalid(rsp1_rvalid),
        .rsp1_rdata (rsp1_rdata),
        .dc_req_bus (dc_req_bus),
        .dc_ready   (dc_ready),
        .dc_rvalid  (dc_rvalid),
        .dc_rdata   (dc_rdata)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int owner;
        bit discard;
    } ent_t;

    ent_t              m_q[$];
    int                m_held;
    logic [31:0]       m_last0, m_last1;
    int                e_lane;
    logic [REQ_WD-1:0] e_bus;
    logic [3:0]        e_flags;
    logic [31:0]       e_rdata0, e_rdata1;

    function automatic logic [REQ_WD-1:0] mk_req(input bit op, input bit cacop, input logic [31:0] addr,
                                                 input logic [3:0] strb, input logic [31:0] wdata);
        return {1'b1, op, addr, 1'b0, strb, wdata, cacop, 2'b00, (cacop ? addr : 32'h0)};
    endfunction

    function automatic logic [REQ_WD-1:0] ld(input logic [31:0] addr);
        return mk_req(1'b0, 1'b0, addr, 4'h0, 32'h0);
    endfunction

    function automatic logic [REQ_WD-1:0] st(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] d);
        return mk_req(1'b1, 1'b0, addr, strb, d);
    endfunction

    function automatic logic [REQ_WD-1:0] rnd_req();
        int k = $urandom_range(0, 9);
        if (k < 5) return ld($urandom);
        if (k < 8) return st($urandom, 4'($urandom), $urandom);
        return mk_req(1'b0, 1'b1, $urandom, 4'h0, 32'h0);
    endfunction

    function automatic bit m_is_read(input logic [REQ_WD-1:0] b);
        return b[105] && !b[104] && !b[34];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_held  = -1;
        m_last0 = '0;
        m_last1 = '0;
    endtask

    task automatic model_eval();
        bit full = (m_q.size() == MAX_OUTST);
        bit rv0 = 0, rv1 = 0;
        e_lane = -1;
        if (m_held >= 0)        e_lane = m_held;
        else if (req0_bus[105]) e_lane = (m_is_read(req0_bus) && full) ? -1 : 0;
        else if (req1_bus[105]) e_lane = (m_is_read(req1_bus) && full) ? -1 : 1;
        e_bus = (e_lane == 0) ? req0_bus : (e_lane == 1) ? req1_bus : '0;
        if (dc_rvalid && m_q.size() > 0 && !m_q[0].discard && !flush) begin
            if (m_q[0].owner == 0) rv0 = 1;
            else                   rv1 = 1;
        end
        e_rdata0 = rv0 ? dc_rdata : m_last0;
        e_rdata1 = rv1 ? dc_rdata : m_last1;
        e_flags  = {dc_ready && e_lane == 0, dc_ready && e_lane == 1, rv0, rv1};
    endtask

    task automatic model_update();
        ent_t e;
        m_last0 = e_rdata0;
        m_last1 = e_rdata1;
        if (dc_rvalid && m_q.size() > 0) void'(m_q.pop_front());
        if (e_lane >= 0 && dc_ready && m_is_read(e_bus)) begin
            e.owner = e_lane;
            e.discard = 1'b0;
            m_q.push_back(e);
        end
        if (flush) foreach (m_q[i]) m_q[i].discard = 1'b1;
        m_held = (e_lane >= 0 && !dc_ready) ? e_lane : -1;
    endtask

    // cyc: settle mid-cycle and compute expectations; adv: commit model and cross the edge.
    task automatic cyc();
        @(negedge clk);
        model_eval();
    endtask

    task automatic adv();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_bus = '0; req1_bus = '0; flush = 0; dc_ready = 0; dc_rvalid = 0; dc_rdata = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        req0_bus = ld(32'h1c000000); dc_ready = 1; dc_rvalid = 1; dc_rdata = 32'h5a5a5a5a;
        @(negedge clk);
        checks++; if (dc_req_bus !== '0) begin errors++; $display("FAIL reset_bus: got %h exp 0", dc_req_bus); end
        checks++; if ({req0_ready, req1_ready, rsp0_rvalid, rsp1_rvalid} !== 4'b0) begin errors++;
            $display("FAIL reset_flags: got %b exp 0000", {req0_ready, req1_ready, rsp0_rvalid, rsp1_rvalid}); end
        checks++; if ({rsp0_rdata, rsp1_rdata} !== 64'h0) begin errors++;
            $display("FAIL reset_rdata: got %h/%h exp 0/0", rsp0_rdata, rsp1_rdata); end
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        cyc();
        checks++; if (dc_req_bus !== '0 || {req0_ready, req1_ready} !== 2'b00) begin errors++;
            $display("FAIL post_reset_idle: got bus %h rdy %b exp 0", dc_req_bus, {req0_ready, req1_ready}); end
        adv();
    endtask

    task automatic test_load_lane0();
        logic [REQ_WD-1:0] r = ld(32'h1c000100);
        req0_bus = r; dc_ready = 1;
        cyc();
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL t1_ready0: got %b exp 1", req0_ready); end
        checks++; if (dc_req_bus !== r) begin errors++; $display("FAIL t1_bus: got %h exp %h", dc_req_bus, r); end
        adv();
        req0_bus = '0; dc_rvalid = 1; dc_rdata = 32'hdeadbeef;
        cyc();
        checks++; if ({rsp0_rvalid, rsp1_rvalid} !== 2'b10) begin errors++;
            $display("FAIL t1_rvalid: got %b exp 10", {rsp0_rvalid, rsp1_rvalid}); end
        checks++; if (rsp0_rdata !== 32'hdeadbeef) begin errors++; $display("FAIL t1_rdata: got %h exp deadbeef", rsp0_rdata); end
        adv();
        dc_rvalid = 0; dc_rdata = $urandom;
        cyc();
        checks++; if (rsp0_rvalid !== 1'b0 || rsp0_rdata !== 32'hdeadbeef) begin errors++;
            $display("FAIL t1_hold: got v=%b d=%h exp v=0 d=deadbeef", rsp0_rvalid, rsp0_rdata); end
        adv();
    endtask

    task automatic test_dual_issue();
        logic [REQ_WD-1:0] a = ld(32'h100), b = ld(32'h104);
        req0_bus = a; req1_bus = b; dc_ready = 1;
        cyc();
        checks++; if ({req0_ready, req1_ready} !== 2'b10 || dc_req_bus !== a) begin errors++;
            $display("FAIL t2_c0: got rdy %b bus %h exp 10 %h", {req0_ready, req1_ready}, dc_req_bus, a); end
        adv();
        req0_bus = '0;
        cyc();
        checks++; if ({req0_ready, req1_ready} !== 2'b01 || dc_req_bus !== b) begin errors++;
            $display("FAIL t2_c1: got rdy %b bus %h exp 01 %h", {req0_ready, req1_ready}, dc_req_bus, b); end
        adv();
        req1_bus = '0; dc_rvalid = 1; dc_rdata = 32'h11;
        cyc();
        checks++; if ({rsp0_rvalid, rsp1_rvalid} !== 2'b10 || rsp0_rdata !== 32'h11) begin errors++;
            $display("FAIL t2_rsp0: got v %b d %h exp 10 11", {rsp0_rvalid, rsp1_rvalid}, rsp0_rdata); end
        adv();
        dc_rdata = 32'h22;
        cyc();
        checks++; if ({rsp0_rvalid, rsp1_rvalid} !== 2'b01 || rsp1_rdata !== 32'h22 || rsp0_rdata !== 32'h11) begin errors++;
            $display("FAIL t2_rsp1: got v %b d1 %h d0 %h exp 01 22 11", {rsp0_rvalid, rsp1_rvalid}, rsp1_rdata, rsp0_rdata); end
        adv();
        dc_rvalid = 0;
    endtask

    task automatic test_hold();
        logic [REQ_WD-1:0] s = st($urandom, 4'b0011, $urandom);
        logic [REQ_WD-1:0] l = ld($urandom);
        logic [31:0] d = $urandom;
        req1_bus = s; dc_ready = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) req0_bus = l;
            if (c == 3) dc_ready = 1;
            cyc();
            checks++; if (dc_req_bus !== s) begin errors++; $display("FAIL t3_bus_c%0d: got %h exp %h", c, dc_req_bus, s); end
            checks++; if ({req0_ready, req1_ready} !== ((c == 3) ? 2'b01 : 2'b00)) begin errors++;
                $display("FAIL t3_rdy_c%0d: got %b exp %b", c, {req0_ready, req1_ready}, (c == 3) ? 2'b01 : 2'b00); end
            adv();
        end
        req1_bus = '0;
        cyc();
        checks++; if (req0_ready !== 1'b1 || dc_req_bus !== l) begin errors++;
            $display("FAIL t3_lane0_after: got rdy %b bus %h exp 1 %h", req0_ready, dc_req_bus, l); end
        adv();
        req0_bus = '0; dc_rvalid = 1; dc_rdata = d;
        cyc();
        checks++; if (rsp0_rvalid !== 1'b1 || rsp0_rdata !== d) begin errors++;
            $display("FAIL t3_rsp: got v %b d %h exp 1 %h", rsp0_rvalid, rsp0_rdata, d); end
        adv();
        dc_rvalid = 0;
    endtask

    task automatic test_fifo_full();
        logic [REQ_WD-1:0] l5 = ld(32'h210), s0 = st(32'h300, 4'hf, $urandom), s1 = st(32'h304, 4'h1, $urandom);
        logic [31:0] d;
        dc_ready = 1;
        for (int i = 0; i < 4; i++) begin
            req0_bus = ld(32'h200 + 32'(4 * i));
            cyc();
            checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL t4_fill%0d: got %b exp 1", i, req0_ready); end
            adv();
        end
        req0_bus = s0;
        cyc();
        checks++; if (req0_ready !== 1'b1 || dc_req_bus !== s0) begin errors++;
            $display("FAIL t4_store_when_full: got rdy %b bus %h exp 1 %h", req0_ready, dc_req_bus, s0); end
        adv();
        req0_bus = l5; req1_bus = s1;
        for (int c = 0; c < 2; c++) begin
            d = $urandom;
            dc_rvalid = (c == 1); dc_rdata = d;
            cyc();
            checks++; if (dc_req_bus !== '0 || {req0_ready, req1_ready} !== 2'b00) begin errors++;
                $display("FAIL t4_blocked_c%0d: got bus %h rdy %b exp 0 00", c, dc_req_bus, {req0_ready, req1_ready}); end
            if (c == 1) begin
                checks++; if (rsp0_rvalid !== 1'b1 || rsp0_rdata !== d) begin errors++;
                    $display("FAIL t4_pop: got v %b d %h exp 1 %h", rsp0_rvalid, rsp0_rdata, d); end
            end
            adv();
        end
        dc_rvalid = 0;
        cyc();
        checks++; if ({req0_ready, req1_ready} !== 2'b10 || dc_req_bus !== l5) begin errors++;
            $display("FAIL t4_load_issues: got rdy %b bus %h exp 10 %h", {req0_ready, req1_ready}, dc_req_bus, l5); end
        adv();
        req0_bus = '0;
        cyc();
        checks++; if ({req0_ready, req1_ready} !== 2'b01 || dc_req_bus !== s1) begin errors++;
            $display("FAIL t4_store1: got rdy %b bus %h exp 01 %h", {req0_ready, req1_ready}, dc_req_bus, s1); end
        adv();
        req1_bus = '0;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            dc_rvalid = 1; dc_rdata = d;
            cyc();
            checks++; if ({rsp0_rvalid, rsp1_rvalid} !== 2'b10 || rsp0_rdata !== d) begin errors++;
                $display("FAIL t4_drain%0d: got v %b d %h exp 10 %h", i, {rsp0_rvalid, rsp1_rvalid}, rsp0_rdata, d); end
            adv();
        end
        dc_rvalid = 0;
    endtask

    task automatic test_flush();
        logic [31:0] h0, h1, d;
        dc_ready = 1;
        req0_bus = ld(32'h400); req1_bus = ld(32'h404);
        cyc(); adv();
        req0_bus = '0;
        cyc(); adv();
        req1_bus = '0; flush = 1;
        cyc(); adv();
        flush = 0;
        h0 = rsp0_rdata; h1 = rsp1_rdata;
        for (int i = 0; i < 2; i++) begin
            dc_rvalid = 1; dc_rdata = $urandom;
            cyc();
            checks++; if ({rsp0_rvalid, rsp1_rvalid} !== 2'b00) begin errors++;
                $display("FAIL t5_flushed%0d: got %b exp 00", i, {rsp0_rvalid, rsp1_rvalid}); end
            checks++; if (rsp0_rdata !== e_rdata0 || rsp1_rdata !== e_rdata1) begin errors++;
                $display("FAIL t5_rdata_hold%0d: got %h/%h exp %h/%h", i, rsp0_rdata, rsp1_rdata, e_rdata0, e_rdata1); end
            adv();
        end
        dc_rvalid = 0;
        // fresh read after the flush must land at the FIFO head
        req1_bus = ld(32'h500);
        cyc();
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL t5_fresh_rdy: got %b exp 1", req1_ready); end
        adv();
        req1_bus = '0; d = $urandom; dc_rvalid = 1; dc_rdata = d;
        cyc();
        checks++; if ({rsp0_rvalid, rsp1_rvalid} !== 2'b01 || rsp1_rdata !== d) begin errors++;
            $display("FAIL t5_fresh_rsp: got v %b d %h exp 01 %h", {rsp0_rvalid, rsp1_rvalid}, rsp1_rdata, d); end
        adv();
        dc_rvalid = 0;
        // flush on the push cycle, then a pop coinciding with flush
        req0_bus = ld(32'h600); flush = 1;
        cyc(); adv();
        req0_bus = ld(32'h604); flush = 0;
        cyc(); adv();
        req0_bus = '0;
        for (int i = 0; i < 2; i++) begin
            dc_rvalid = 1; dc_rdata = $urandom; flush = (i == 1);
            cyc();
            checks++; if ({rsp0_rvalid, rsp1_rvalid} !== 2'b00) begin errors++;
                $display("FAIL t5_same_cycle%0d: got %b exp 00", i, {rsp0_rvalid, rsp1_rvalid}); end
            adv();
        end
        dc_rvalid = 0; flush = 0;
    endtask

    task automatic test_async_reset();
        logic [REQ_WD-1:0] c = ld(32'h708), r = ld(32'h800);
        logic [31:0] d = $urandom | 32'h1;
        dc_ready = 1;
        req0_bus = ld(32'h700); cyc(); adv();
        req0_bus = ld(32'h704); cyc(); adv();
        req0_bus = c; dc_ready = 0;
        cyc();
        checks++; if (dc_req_bus !== c || req0_ready !== 1'b0) begin errors++;
            $display("FAIL t6_hold_entry: got bus %h rdy %b exp %h 0", dc_req_bus, req0_ready, c); end
        adv();
        #2 reset = 1'b1;
        #1;
        checks++; if (dc_req_bus !== '0 || {req0_ready, req1_ready, rsp0_rvalid, rsp1_rvalid} !== 4'b0) begin errors++;
            $display("FAIL t6_async_out: got bus %h flags %b exp 0", dc_req_bus, {req0_ready, req1_ready, rsp0_rvalid, rsp1_rvalid}); end
        checks++; if ({rsp0_rdata, rsp1_rdata} !== 64'h0) begin errors++;
            $display("FAIL t6_async_rdata: got %h/%h exp 0/0", rsp0_rdata, rsp1_rdata); end
        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        req1_bus = r; dc_ready = 1;
        cyc();
        checks++; if ({req0_ready, req1_ready} !== 2'b01 || dc_req_bus !== r) begin errors++;
            $display("FAIL t6_idle_after: got rdy %b bus %h exp 01 %h", {req0_ready, req1_ready}, dc_req_bus, r); end
        adv();
        req1_bus = '0; dc_rvalid = 1; dc_rdata = d;
        cyc();
        checks++; if ({rsp0_rvalid, rsp1_rvalid} !== 2'b01 || rsp1_rdata !== d) begin errors++;
            $display("FAIL t6_fifo_empty: got v %b d %h exp 01 %h", {rsp0_rvalid, rsp1_rvalid}, rsp1_rdata, d); end
        adv();
        dc_rvalid = 0;
    endtask

    task automatic test_random();
        logic [REQ_WD-1:0] p0 = '0, p1 = '0;
        for (int n = 0; n < 400; n++) begin
            if (p0 == '0 && $urandom_range(0, 2) == 0) p0 = rnd_req();
            if (p1 == '0 && $urandom_range(0, 2) == 0) p1 = rnd_req();
            req0_bus  = p0;
            req1_bus  = p1;
            dc_ready  = ($urandom_range(0, 3) != 0);
            dc_rvalid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            dc_rdata  = $urandom;
            flush     = ($urandom_range(0, 15) == 0);
            cyc();
            checks++; if (dc_req_bus !== e_bus) begin errors++;
                $display("FAIL rnd_bus@%0d: got %h exp %h", n, dc_req_bus, e_bus); end
            checks++; if ({req0_ready, req1_ready, rsp0_rvalid, rsp1_rvalid} !== e_flags) begin errors++;
                $display("FAIL rnd_flags@%0d: got %b exp %b", n, {req0_ready, req1_ready, rsp0_rvalid, rsp1_rvalid}, e_flags); end
            checks++; if (rsp0_rdata !== e_rdata0 || rsp1_rdata !== e_rdata1) begin errors++;
                $display("FAIL rnd_rdata@%0d: got %h/%h exp %h/%h", n, rsp0_rdata, rsp1_rdata, e_rdata0, e_rdata1); end
            if (e_flags[3]) p0 = '0;
            if (e_flags[2]) p1 = '0;
            adv();
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_load_lane0();
        test_dual_issue();
        test_hold();
        test_fifo_full();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
